// File: rtl/noc_arbiter_rr.sv
// Round-robin output-port arbiter with RTS/DCTS handshake towards the downstream router.
// An optional hold limit forces rotation away from a port that keeps requesting.
module noc_arbiter_rr #(
    parameter int N_PORTS  = 5,
    parameter int HOLD_MAX = 0,
    parameter int CNT_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PORTS-1:0] req,
    input  logic               DCTS,
    output logic [N_PORTS-1:0] grant,
    output logic [N_PORTS-1:0] xbar_sel,
    output logic               RTS,
    output logic [CNT_W-1:0]   hold_cnt
);

    // Bits [N_PORTS-1:0] are OWN[i]; the top bit is IDLE.
    localparam int IDLE_BIT = N_PORTS;

    logic [N_PORTS:0] owner;
    logic [N_PORTS:0] next_owner;
    logic [N_PORTS:0] owner_next;
    logic             rts_next;
    logic [CNT_W-1:0] hold_cnt_next;
    logic             stall;
    logic             others_req;
    logic             cur_req;
    logic             hold_expired;
    logic             found;
    int               idx;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner           <= '0;
            owner[IDLE_BIT] <= 1'b1;
            RTS             <= 1'b0;
            hold_cnt        <= '0;
        end else begin
            owner    <= owner_next;
            RTS      <= rts_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    // Next-state logic.
    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        next_owner    = '0;
        found         = 1'b0;
        idx           = 0;
        others_req    = |(req & ~owner[N_PORTS-1:0]);
        cur_req       = |(req & owner[N_PORTS-1:0]);
        hold_expired  = (HOLD_MAX != 0) && (int'(hold_cnt) >= HOLD_MAX) && others_req;

        if (owner[IDLE_BIT]) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (req[i] && !found) begin
                    next_owner[i] = 1'b1;
                    found         = 1'b1;
                end
            end
            if (!found) next_owner[IDLE_BIT] = 1'b1;
        end else if (cur_req && !hold_expired) begin
            next_owner = owner;
        end else begin
            // Scan upward from the current owner, wrapping, excluding the owner itself.
            for (int c = 0; c < N_PORTS; c++) begin
                if (owner[c]) begin
                    for (int k = 1; k < N_PORTS; k++) begin
                        idx = (c + k) % N_PORTS;
                        if (req[idx] && !found) begin
                            next_owner[idx] = 1'b1;
                            found           = 1'b1;
                        end
                    end
                end
            end
            if (!found) begin
                if (cur_req) next_owner = owner;
                else         next_owner[IDLE_BIT] = 1'b1;
            end
        end

        stall      = RTS && !DCTS;
        owner_next = stall ? owner : next_owner;

        if (owner[IDLE_BIT])  rts_next = 1'b0;
        else if (RTS && DCTS) rts_next = 1'b0;
        else                  rts_next = 1'b1;

        if (owner_next != owner || owner[IDLE_BIT]) hold_cnt_next = '0;
        else if (|grant)                            hold_cnt_next = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;
        else                                        hold_cnt_next = hold_cnt;
    end

    // Outputs.
    always_comb begin
        xbar_sel = owner[N_PORTS-1:0];
        grant    = owner[N_PORTS-1:0] & {N_PORTS{RTS & DCTS}};
    end

endmodule

// File: tb/tb_noc_arbiter_rr.sv
// Self-checking bench for noc_arbiter_rr: directed vector table, hold-limit sequences,
// and randomized traffic against a behavioural model for HOLD_MAX=0 and HOLD_MAX=3.
module tb_noc_arbiter_rr;

    localparam int N = 5;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         dcts;

    logic [N-1:0] a_grant, a_xbar, b_grant, b_xbar;
    logic         a_rts, b_rts;
    logic [W-1:0] a_cnt, b_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    noc_arbiter_rr #(.N_PORTS(N), .HOLD_MAX(0), .CNT_W(W)) dut_a (
        .clk(clk), .rst(rst), .req(req), .DCTS(dcts),
        .grant(a_grant), .xbar_sel(a_xbar), .RTS(a_rts), .hold_cnt(a_cnt)
    );

    noc_arbiter_rr #(.N_PORTS(N), .HOLD_MAX(3), .CNT_W(W)) dut_b (
        .clk(clk), .rst(rst), .req(req), .DCTS(dcts),
        .grant(b_grant), .xbar_sel(b_xbar), .RTS(b_rts), .hold_cnt(b_cnt)
    );

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic         dcts;
        logic [N-1:0] grant;
        logic [N-1:0] xbar;
        logic         rts;
        logic [W-1:0] cnt;
    } vec_t;

    vec_t vecs[25];

    // Behavioural model state, one slot per instance; owner -1 means idle.
    int   m_owner[2];
    logic m_rts[2];
    int   m_cnt[2];
    int   m_hold[2] = '{0, 3};

    function automatic vec_t mk(logic r, logic [N-1:0] q, logic d,
                                logic [N-1:0] g, logic [N-1:0] x, logic t, logic [W-1:0] c);
        vec_t v;
        v.rst = r; v.req = q; v.dcts = d; v.grant = g; v.xbar = x; v.rts = t; v.cnt = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [N-1:0] q, input logic d);
        @(negedge clk);
        rst  = r;
        req  = q;
        dcts = d;
        #1;
    endtask

    function automatic logic [N-1:0] m_xbar(int k);
        return (m_owner[k] >= 0) ? (N'(1) << m_owner[k]) : '0;
    endfunction

    function automatic logic [N-1:0] m_grant(int k);
        return (m_rts[k] && dcts) ? m_xbar(k) : '0;
    endfunction

    task automatic model_update(input int k);
        int  nxt, cur, new_owner;
        bit  others, expired;
        cur = m_owner[k];
        if (rst) begin
            m_owner[k] = -1; m_rts[k] = 1'b0; m_cnt[k] = 0;
            return;
        end
        nxt = -1;
        if (cur < 0) begin
            for (int i = N - 1; i >= 0; i--) if (req[i]) nxt = i;
        end else begin
            others  = (req & ~(N'(1) << cur)) != 0;
            expired = (m_hold[k] != 0) && (m_cnt[k] >= m_hold[k]) && others;
            if (req[cur] && !expired) nxt = cur;
            else begin
                for (int s = N - 1; s >= 1; s--) if (req[(cur + s) % N]) nxt = (cur + s) % N;
                if (nxt < 0 && req[cur]) nxt = cur;
            end
        end
        new_owner = (m_rts[k] && !dcts) ? cur : nxt;
        if (new_owner != cur || cur < 0)  m_cnt[k] = 0;
        else if (m_grant(k) != 0)         m_cnt[k] = (m_cnt[k] < 15) ? m_cnt[k] + 1 : 15;
        m_rts[k]   = (cur < 0) ? 1'b0 : (m_rts[k] && dcts) ? 1'b0 : 1'b1;
        m_owner[k] = new_owner;
    endtask

    initial begin
        int   g1, rotated, cnt_at;
        logic [N-1:0] rq;

        // Reset held with every port requesting, then directed table.
        vecs[0]  = mk(0, 5'b11111, 1, 5'b00000, 5'b00000, 0, 0);
        vecs[1]  = mk(0, 5'b11111, 1, 5'b00000, 5'b00001, 0, 0);
        vecs[2]  = mk(0, 5'b11111, 1, 5'b00001, 5'b00001, 1, 0);
        vecs[3]  = mk(0, 5'b00000, 1, 5'b00000, 5'b00001, 0, 1);
        vecs[4]  = mk(0, 5'b00000, 1, 5'b00000, 5'b00000, 1, 0);
        vecs[5]  = mk(0, 5'b00100, 1, 5'b00000, 5'b00000, 0, 0);
        vecs[6]  = mk(0, 5'b00100, 1, 5'b00000, 5'b00100, 0, 0);
        vecs[7]  = mk(0, 5'b00100, 1, 5'b00100, 5'b00100, 1, 0);
        vecs[8]  = mk(0, 5'b00100, 1, 5'b00000, 5'b00100, 0, 1);
        vecs[9]  = mk(0, 5'b00100, 1, 5'b00100, 5'b00100, 1, 1);
        vecs[10] = mk(0, 5'b10000, 1, 5'b00000, 5'b00100, 0, 2);
        vecs[11] = mk(0, 5'b10000, 1, 5'b10000, 5'b10000, 1, 0);
        vecs[12] = mk(0, 5'b00011, 1, 5'b00000, 5'b10000, 0, 1);
        vecs[13] = mk(0, 5'b00010, 1, 5'b00001, 5'b00001, 1, 0);
        vecs[14] = mk(0, 5'b00010, 1, 5'b00000, 5'b00010, 0, 0);
        vecs[15] = mk(0, 5'b00010, 0, 5'b00000, 5'b00010, 1, 0);
        vecs[16] = mk(0, 5'b01000, 0, 5'b00000, 5'b00010, 1, 0);
        vecs[17] = mk(0, 5'b01000, 0, 5'b00000, 5'b00010, 1, 0);
        vecs[18] = mk(0, 5'b01000, 0, 5'b00000, 5'b00010, 1, 0);
        vecs[19] = mk(0, 5'b01000, 0, 5'b00000, 5'b00010, 1, 0);
        vecs[20] = mk(0, 5'b01000, 1, 5'b00010, 5'b00010, 1, 0);
        vecs[21] = mk(0, 5'b01000, 1, 5'b00000, 5'b01000, 0, 0);
        vecs[22] = mk(1, 5'b01000, 1, 5'b01000, 5'b01000, 1, 0);
        vecs[23] = mk(0, 5'b01000, 1, 5'b00000, 5'b00000, 0, 0);
        vecs[24] = mk(0, 5'b01000, 1, 5'b00000, 5'b01000, 0, 0);

        drive(1, 5'b11111, 1);
        drive(1, 5'b11111, 1);
        for (int i = 0; i < 25; i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].dcts);
            check($sformatf("vec%0d_grant", i), a_grant, vecs[i].grant);
            check($sformatf("vec%0d_xbar", i), a_xbar, vecs[i].xbar);
            check($sformatf("vec%0d_rts", i), a_rts, vecs[i].rts);
            check($sformatf("vec%0d_cnt", i), a_cnt, vecs[i].cnt);
        end

        // Hold limit 3: port 1 gets exactly three grants, then port 2 takes over.
        drive(1, 5'b00110, 1);
        g1 = 0; rotated = 0; cnt_at = -1;
        for (int i = 0; i < 40; i++) begin
            drive(0, 5'b00110, 1);
            if (b_grant == 5'b00010) g1++;
            if (b_xbar == 5'b00100) begin
                rotated = 1;
                cnt_at  = b_cnt;
                break;
            end
        end
        check("hold_grants_port1", g1, 3);
        check("hold_rotated", rotated, 1);
        check("hold_cnt_restart", cnt_at, 0);

        // Sole requester keeps ownership past the limit; counter saturates.
        drive(1, 5'b00010, 1);
        g1 = 0;
        for (int i = 0; i < 40; i++) begin
            drive(0, 5'b00010, 1);
            if (b_grant == 5'b00010) g1++;
        end
        check("sole_grants", g1, 19);
        check("sole_xbar", b_xbar, 5'b00010);
        check("sole_cnt_sat", b_cnt, 15);

        // Randomized traffic against the model for both instances.
        drive(1, '0, 1);
        model_update(0);
        model_update(1);
        rq = '0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) rq = N'($urandom);
            drive($urandom_range(0, 99) == 0, rq, $urandom_range(0, 3) != 0);
            check("rnd_a_grant", a_grant, m_grant(0));
            check("rnd_a_xbar", a_xbar, m_xbar(0));
            check("rnd_a_rts", a_rts, m_rts[0]);
            check("rnd_a_cnt", a_cnt, m_cnt[0]);
            check("rnd_b_grant", b_grant, m_grant(1));
            check("rnd_b_xbar", b_xbar, m_xbar(1));
            check("rnd_b_rts", b_rts, m_rts[1]);
            check("rnd_b_cnt", b_cnt, m_cnt[1]);
            model_update(0);
            model_update(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/noc_arbiter_rr.md
# noc_arbiter_rr

Parametrised round-robin output-port arbiter for the NoC router. It is the successor to the fixed 5-input N/E/W/S/L arbiter.
- One instance sits on each router output port, arbitrating `N_PORTS` input requests and driving one-hot crossbar select.
- It runs the RTS/DCTS flow-control handshake towards the downstream router.
- New over the previous generation: port count is a parameter, and an optional hold limit forces rotation so a continuously requesting port cannot starve the others.

## Interface
- `N_PORTS`, 5: number of requesting inputs (2..16). Index 0 is Local; in the 5-port build 1..4 are N, E, W, S.
- `HOLD_MAX`, 0: maximum consecutive grants to one port while another port requests. 0 = unlimited, matching the previous-generation behaviour.
- `CNT_W`, 4: width of the hold counter. Requires `HOLD_MAX` < 2^`CNT_W`.
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset. Sampled on the `clk` rising edge.
- `req`, in, `N_PORTS`: per-input request, level-sensitive.
- `DCTS`, in, 1: downstream clear-to-send.
- `grant`, out, `N_PORTS`: one-hot or zero grant to the selected input. Combinational.
- `xbar_sel`, out, `N_PORTS`: one-hot crossbar select for the current owner. All zero when idle.
- `RTS`, out, 1: request-to-send to downstream, registered.
- `hold_cnt`, out, `CNT_W`: consecutive-grant count for the current owner (debug/verification).

## Operation
- State register `owner`: IDLE or OWN[i] for i in 0..`N_PORTS`-1. Encoded one-hot, `N_PORTS`+1 bits.
- Registers `RTS` and `hold_cnt` are listed with their update rules below.
- Stall rule: if `RTS`=1 and `DCTS`=0, `owner` holds.
  - Otherwise `owner` <= next_owner.
- next_owner from IDLE: the lowest-index requesting port. If `req`=0, stay IDLE.
- next_owner from OWN[c]:
  - If `req[c]`=1 and not hold-expired, stay OWN[c].
  - Otherwise scan (c+1), (c+2), ... mod `N_PORTS`, excluding c; the first requester wins.
  - If none is found, fall back to c when `req[c]`=1, even if hold-expired; else IDLE.
- Hold-expired: `HOLD_MAX`≠0, `hold_cnt`≥`HOLD_MAX`, and some other port is requesting.
- `RTS` next value:
  - 0 if `owner`=IDLE.
  - Else 0 if (`RTS`=1 and `DCTS`=1).
  - Else 1.
- `grant[i]` = (`owner`=OWN[i]) & `RTS` & `DCTS`. At most one bit is set.
- `xbar_sel[i]` = (`owner`=OWN[i]), independent of `RTS`.
- `hold_cnt` update, evaluated in this order:
  - Clears when `owner` changes or is IDLE.
  - Increments on a cycle with any `grant` bit set, saturating at 2^`CNT_W`-1.
  - Otherwise holds.
- Requests are not latched. A port dropping `req` while owner is released at the next non-stalled update.

## Timing
- Reset values: `owner`=IDLE, `RTS`=0, `hold_cnt`=0, `grant`=0, `xbar_sel`=0.
- Reset mid-transfer aborts immediately. No grant is issued in the cycle after reset.
- Latency, IDLE to first grant with `DCTS`=1:
  - Request seen at cycle t.
  - `owner` updates at t+1 with `RTS`=0.
  - `RTS`=1 at t+2, and `grant` is high in cycle t+2.
- Steady state: `RTS` toggles 1,0,1,... giving at most one grant every 2 cycles per output, identical to the previous generation.
- `DCTS` low with `RTS`=1: `RTS` stays 1, `owner` frozen, `grant`=0 until `DCTS` rises. The grant occurs in the cycle `DCTS` is sampled high.
- Simultaneous requests from IDLE: lowest index wins. Round-robin applies only from an owned state.
- `HOLD_MAX`=0: the counter still counts (saturating) but never forces rotation.

## Test plan
1. Reset with `req`=5'b11111 -> `RTS`=0, `grant`=0, `xbar_sel`=0 in the cycle after reset. OWN[0] is taken at the next update, and `grant`=5'b00001 two cycles after reset release.
2. From IDLE, `req`=5'b00100 held, `DCTS`=1 -> `xbar_sel`=5'b00100 one cycle later. `grant`=5'b00100 on every second cycle thereafter; `RTS` pattern is 0,1,0,1.
3. Owner OWN[4], `req` changes to 5'b00011 -> next owner is OWN[0] (wrap-around scan from 4), then OWN[1] after port 0 drops.
4. `DCTS`=0 for 5 cycles with `RTS`=1 and the request switched to another port -> `owner` and `xbar_sel` unchanged, `grant`=0. The grant to the original owner is issued in the cycle `DCTS` returns to 1.
5. `HOLD_MAX`=3, `req`=5'b00110 held, owner OWN[1] -> exactly 3 grants to port 1, then rotation to OWN[2], whose count restarts at 0. With `req`=5'b00010 only, port 1 keeps ownership past 3 grants.
6. Assert `rst` while `RTS`=1 and `owner`=OWN[3] -> the next cycle shows all outputs at reset values, and `hold_cnt`=0.
